// File: rtl/tff_pkg.sv
// Shared types for the T-flip-flop counter family: operation modes and width limit.
// Pure declarations, no latency or backpressure (types and constants only).
// Imported by tff_cell and tff_counter.
package tff_pkg;

  localparam int TFF_MAX_WIDTH = 16;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DOWN = 2'b10,
    MODE_LOAD = 2'b11
  } mode_t;

endpackage

// File: rtl/tff_cell.sv
// One-bit T flip-flop with synchronous active-high reset.
// Latency: 1 cycle from t to q; no backpressure (free-running storage cell).
// Building block replicated per bit by tff_counter.
module tff_cell
  import tff_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 1'b0;
    end else begin
      q <= q ^ t;
    end
  end

endmodule

// File: rtl/tff_counter.sv
// Modulo up/down/load counter built from WIDTH T-cells; TFF_COUNTER_SAT_EN saturates instead of wrapping.
// Latency: 1 cycle from control change to q; tc is combinational and predicts wrap.
// No backpressure: en=0 or mode=hold freezes the count.
module tff_counter
  import tff_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int MODULO = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  if ((WIDTH < 2) || (WIDTH > TFF_MAX_WIDTH) ||
      (MODULO < 2) || (MODULO > (1 << WIDTH))) begin : g_param_check
    $fatal(1, "tff_counter: illegal WIDTH/MODULO combination");
  end

  localparam logic [WIDTH-1:0] QMAX = WIDTH'(MODULO - 1);
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  mode_t            op;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] t;
  logic             wrap_next;
  logic             at_top;
  logic             at_bottom;

  assign op        = mode_t'(mode);
  assign at_top    = (q == QMAX);
  assign at_bottom = (q == ZERO);

  always_comb begin
    q_next    = q;
    wrap_next = 1'b0;
    if (en) begin
      case (op)
        MODE_UP: begin
          if (at_top) begin
`ifdef TFF_COUNTER_SAT_EN
            q_next    = QMAX;
`else
            q_next    = ZERO;
            wrap_next = 1'b1;
`endif
          end else begin
            q_next = q + ONE;
          end
        end
        MODE_DOWN: begin
          if (at_bottom) begin
`ifdef TFF_COUNTER_SAT_EN
            q_next    = ZERO;
`else
            q_next    = QMAX;
            wrap_next = 1'b1;
`endif
          end else begin
            q_next = q - ONE;
          end
        end
        MODE_LOAD: begin
          q_next = (d > QMAX) ? QMAX : d;
        end
        default: begin
          q_next = q;
        end
      endcase
    end
  end

  // Load and count share one path: each cell only sees which bits must flip.
  assign t = q ^ q_next;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_cell u_cell (
      .clk (clk),
      .rst (rst),
      .t   (t[i]),
      .q   (q[i])
    );
  end

  assign tc = en & (((op == MODE_UP) & at_top) | ((op == MODE_DOWN) & at_bottom));

`ifdef TFF_COUNTER_SAT_EN
  logic unused_wrap_next;
  assign unused_wrap_next = wrap_next;
  assign wrap = 1'b0;
`else
  logic wrap_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_next;
    end
  end

  assign wrap = wrap_q;
`endif

endmodule

// File: tb/tb_tff_counter.sv
// Drives a MODULO=10 and a MODULO=16 counter in lockstep against an arithmetic reference model.
module tb_tff_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [3:0] d;

  logic [3:0] q10, q16;
  logic       tc10, tc16, wrap10, wrap16;

  int errors = 0;
  int checks = 0;
  int mq10 = 0;
  int mq16 = 0;
  bit mw10 = 1'b0;
  bit mw16 = 1'b0;

  always #5 clk = ~clk;

  tff_counter #(.WIDTH(4), .MODULO(10)) u_dut10 (
    .clk (clk), .rst (rst), .en (en), .mode (mode), .d (d),
    .q (q10), .tc (tc10), .wrap (wrap10)
  );

  tff_counter #(.WIDTH(4), .MODULO(16)) u_dut16 (
    .clk (clk), .rst (rst), .en (en), .mode (mode), .d (d),
    .q (q16), .tc (tc16), .wrap (wrap16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_q(int q, int md, bit r, bit e, int m, int dv);
    if (r) return 0;
    if (!e) return q;
    case (m)
`ifdef TFF_COUNTER_SAT_EN
      1: return (q + 1 > md - 1) ? md - 1 : q + 1;
      2: return (q - 1 < 0) ? 0 : q - 1;
`else
      1: return (q + 1) % md;
      2: return (q + md - 1) % md;
`endif
      3: return (dv < md) ? dv : md - 1;
      default: return q;
    endcase
  endfunction

  function automatic bit ref_wrap(int q, int md, bit r, bit e, int m);
`ifdef TFF_COUNTER_SAT_EN
    return 1'b0;
`else
    if (r || !e) return 1'b0;
    return ((m == 1) && (q + 1 == md)) || ((m == 2) && (q == 0));
`endif
  endfunction

  function automatic bit ref_tc(int q, int md, bit e, int m);
    return e && (((m == 1) && (q == md - 1)) || ((m == 2) && (q == 0)));
  endfunction

  // One clock: drive, check tc before the edge, advance the model, check registered outputs.
  task automatic cyc(input bit r, input bit e, input int m, input int dv);
    rst  = r;
    en   = e;
    mode = m[1:0];
    d    = dv[3:0];
    #1;
    chk("tc10", {31'b0, tc10}, {31'b0, ref_tc(mq10, 10, e, m)});
    chk("tc16", {31'b0, tc16}, {31'b0, ref_tc(mq16, 16, e, m)});
    @(posedge clk);
    mw10 = ref_wrap(mq10, 10, r, e, m);
    mq10 = ref_q(mq10, 10, r, e, m, dv);
    mw16 = ref_wrap(mq16, 16, r, e, m);
    mq16 = ref_q(mq16, 16, r, e, m, dv);
    #1;
    chk("q10", {28'b0, q10}, mq10);
    chk("wrap10", {31'b0, wrap10}, {31'b0, mw10});
    chk("q16", {28'b0, q16}, mq16);
    chk("wrap16", {31'b0, wrap16}, {31'b0, mw16});
  endtask

  initial begin
    int up_exp[12];
    up_exp = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};

    // reset for two edges
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("reset_q", {28'b0, q10}, 0);
    chk("reset_wrap", {31'b0, wrap10}, 0);

    // count up through the modulo-10 wrap
    for (int i = 0; i < 12; i++) begin
      cyc(0, 1, 1, 0);
`ifndef TFF_COUNTER_SAT_EN
      chk("up_seq", {28'b0, q10}, up_exp[i]);
      chk("up_wrap", {31'b0, wrap10}, (i == 9) ? 1 : 0);
`endif
    end

    // load 2 then count down through zero
    cyc(0, 1, 3, 2);
    for (int i = 0; i < 4; i++) cyc(0, 1, 2, 0);

    // load clamp, then enable low with mode=up
    cyc(0, 1, 3, 13);
    chk("clamp_q", {28'b0, q10}, 9);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);
    chk("hold_q", {28'b0, q10}, 9);

    // reset mid-count at q=5
    cyc(0, 1, 3, 4);
    cyc(0, 1, 1, 0);
    cyc(1, 1, 1, 0);
    chk("midrst_q", {28'b0, q10}, 0);
    cyc(0, 1, 1, 0);
    chk("after_rst_q", {28'b0, q10}, 1);

    // full-range rollover on the modulo-16 instance
    cyc(0, 1, 3, 15);
    cyc(0, 1, 1, 0);
    chk("roll_q16", {28'b0, q16}, 0);
`ifndef TFF_COUNTER_SAT_EN
    chk("roll_wrap16", {31'b0, wrap16}, 1);
`endif
    cyc(0, 1, 1, 0);

    // limit behaviour at both ends
    cyc(0, 1, 3, 8);
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0);
    cyc(0, 1, 3, 1);
    for (int i = 0; i < 2; i++) cyc(0, 1, 2, 0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 24) == 0),
          ($urandom_range(0, 3) != 0),
          int'($urandom_range(0, 3)),
          int'($urandom_range(0, 15)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tff_counter.md
Name: tff_counter

Overview:
- Parametrised synchronous up/down/load counter built from a bank of T flip-flop cells, one cell per bit.
- Successor to the single-bit T flip-flop: adds generic width, modulo wrap, direction control, parallel load, terminal-count flag and wrap pulse.
- Used as the general-purpose event/interval counter in the sequential-logic library, and as the reference for later divider and timer blocks.

Parameters:
- WIDTH, 4, counter width in bits; legal range 2..16.
- MODULO, 16, count range 0..MODULO-1; legal range 2..2**WIDTH; checked at elaboration, out-of-range values are fatal.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- en  input  1  count enable; 0 = hold regardless of mode
- mode  input  2  operation: 00 hold, 01 up, 10 down, 11 load
- d  input  WIDTH  parallel load value
- q  output  WIDTH  registered count
- tc  output  1  combinational terminal count
- wrap  output  1  registered one-cycle pulse on wrap-around

Behaviour:
- All state updates occur on the rising edge of clk only.
- Reset:
  - rst=1 at a clock edge: q=0 and wrap=0 at that edge.
  - rst has priority over en and mode.
  - rst asserted mid-count clears on the next edge; the counter resumes from 0 on the first edge after rst falls.
- Priority order: rst > en=0 (hold) > mode.
- Hold (en=0 or mode=00): q unchanged; wrap=0.
- Up (en=1, mode=01):
  - q<MODULO-1: q<=q+1.
  - q==MODULO-1: q<=0 and wrap<=1.
- Down (en=1, mode=10):
  - q>0: q<=q-1.
  - q==0: q<=MODULO-1 and wrap<=1.
- Load (en=1, mode=11):
  - d<MODULO: q<=d.
  - d>=MODULO: q<=MODULO-1 (clamped).
  - wrap<=0 in both cases.
- wrap is 1 for exactly the one cycle after a wrap edge; otherwise 0.
- tc = en & ((mode==01 & q==MODULO-1) | (mode==10 & q==0)).
  - tc is combinational and predicts wrap for the next edge.
  - tc is 0 in hold and load.
- Arithmetic: next value is computed at WIDTH bits; no carry leaves the block except via wrap.
- Latency: 1 cycle from a control change to q.
- Cell structure:
  - Toggle vector t = q ^ q_next; each bit is a T-cell holding q[i] <= q[i] ^ t[i].
  - Cell reset is synchronous; load is expressed through t, not through a separate D path.
- When MODULO==2**WIDTH, wrap occurs at the natural binary rollover.

Optional Feature:
- Macro: TFF_COUNTER_SAT_EN.
- Defined:
  - Up at MODULO-1 holds at MODULO-1; down at 0 holds at 0.
  - wrap is tied to 0.
  - tc keeps the same equation and signals "at limit".
  - Load clamping is unchanged.
- Undefined: wrap-around behaviour as specified above.

Decomposition:
- Shared package tff_pkg holds:
  - mode typedef: enum of 2 bits: MODE_HOLD=00, MODE_UP=01, MODE_DOWN=10, MODE_LOAD=11.
  - Constant TFF_MAX_WIDTH=16.
- Sub-module tff_cell: 1-bit T flip-flop with ports clk, rst, t, q.
  - Synchronous active-high reset.
  - Instantiated WIDTH times by a generate loop.

Test Plan:
- Reset and count up: WIDTH=4, MODULO=10, rst=1 for 2 edges, then en=1, mode=01 for 12 edges.
  - Required: q=0,1..9,0,1,2.
  - wrap=1 only in the cycle after 9->0; tc=1 while q=9.
- Down wrap: load d=2, then mode=10 for 4 edges.
  - Required: q=2,1,0,9,8; wrap pulse after 0->9; tc=1 while q=0.
- Load clamp and hold: mode=11 with d=13 gives q=9; then en=0 with mode=01 for 3 edges.
  - Required: q stays 9, wrap=0, tc=0.
- Reset mid-operation: counting up at q=5, assert rst for 1 edge while mode=01.
  - Required: q=0 and wrap=0 at that edge; next edge q=1.
- Full-range rollover: WIDTH=4, MODULO=16, start at q=15, up.
  - Required: q=0 and wrap=1 for one cycle.
- With TFF_COUNTER_SAT_EN defined, MODULO=10: up from 8 for 3 edges gives 9,9,9; down from 1 for 2 edges gives 0,0.
  - Required: wrap stays 0; tc=1 while at the limit.
